// File: rtl/uart_pkg.sv
// Purpose: shared types and constants for the UART transmit-side arbitration blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: 2-bit state encoding for the arbiter sequencer and the byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE      = 2'd0;
    localparam state_t ST_LAUNCH    = 2'd1;
    localparam state_t ST_WAIT_BUSY = 2'd2;
    localparam state_t ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/rr_pick.sv
// Purpose: combinational rotating-priority encoder; picks the first request above the last grant.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether to act on the pick.
// Ports:
//   req     - N-bit request vector
//   last    - index of the previous winner; search starts at (last+1) mod N and wraps
//   winner  - index of the chosen requester (equals last when nothing is requesting)
//   any_req - at least one request bit is set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    logic [IW-1:0] cand;

    // Walk the offsets from farthest to nearest so the nearest set bit above
    // 'last' is the final assignment and therefore wins.
    always_comb begin
        winner  = last;
        any_req = |req;
        cand    = '0;
        for (int d = N; d >= 1; d--) begin
            cand = IW'((int'(last) + d) % N);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: round-robin share of one uart_tx between N byte producers; capture, launch, track frame.
// Latency: ack on the grant edge, o_tx_ready one cycle later; IDLE again one cycle after i_tx_next rises.
// Backpressure: grants only when i_en and i_tx_next are high; producers hold valid/data until acked.
// Ports:
//   i_clk, i_rst              - clock and async active-high reset
//   i_en                      - gates new grants only; an in-flight byte always completes
//   i_req_valid, i_req_data   - per-requester valid level and packed bytes (requester k at [8k+7:8k])
//   o_req_ack                 - one-hot single-cycle accept pulse
//   o_tx_data, o_tx_ready     - byte and one-cycle launch strobe towards uart_tx
//   i_tx_next                 - uart_tx idle level
//   o_busy, o_grant_id        - not-idle flag and last granted index
//   o_timeout                 - sticky flag: transmitter never left idle after a launch
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N       = 4,
    parameter int TIMEOUT = 64,
    parameter int TW      = 7
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [N-1:0]           i_req_valid,
    input  logic [BYTE_W*N-1:0]    i_req_data,
    output logic [N-1:0]           o_req_ack,
    output logic [BYTE_W-1:0]      o_tx_data,
    output logic                   o_tx_ready,
    input  logic                   i_tx_next,
    output logic                   o_busy,
    output logic [$clog2(N)-1:0]   o_grant_id,
    output logic                   o_timeout
);

    localparam int IW = $clog2(N);

    state_t            state_q;
    state_t            state_d;
    logic [TW-1:0]     cnt_q;
    logic [TW-1:0]     cnt_d;

    logic [N-1:0]      ack_d;
    logic [BYTE_W-1:0] data_d;
    logic              ready_d;
    logic              busy_d;
    logic [IW-1:0]     gid_d;
    logic              timeout_d;

    logic [IW-1:0]     winner;
    logic              any_req;
    logic [BYTE_W-1:0] sel_byte;
    logic              grant;
    logic              timeout_hit;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req     (i_req_valid),
        .last    (o_grant_id),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < N; k++) begin
            if (winner == IW'(k)) begin
                sel_byte = i_req_data[k*BYTE_W +: BYTE_W];
            end
        end
    end

    assign grant = (state_q == ST_IDLE) && i_en && i_tx_next && any_req;

    // The counter starts at zero on the edge leaving LAUNCH, so the flag fires
    // exactly TIMEOUT cycles after the launch strobe becomes visible.
    assign timeout_hit = (state_q == ST_WAIT_BUSY) && i_tx_next &&
                         (cnt_q == TW'(TIMEOUT - 1));

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            o_req_ack  <= '0;
            o_tx_data  <= '0;
            o_tx_ready <= 1'b0;
            o_busy     <= 1'b0;
            o_grant_id <= IW'(N - 1);
            o_timeout  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            o_req_ack  <= ack_d;
            o_tx_data  <= data_d;
            o_tx_ready <= ready_d;
            o_busy     <= busy_d;
            o_grant_id <= gid_d;
            o_timeout  <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!i_tx_next) begin
                    state_d = ST_WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                // No timeout here: frame length scales with the oversampling ratio.
                if (i_tx_next) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values; all outputs are registered.
    always_comb begin
        ack_d = '0;
        for (int k = 0; k < N; k++) begin
            ack_d[k] = grant && (winner == IW'(k));
        end
        data_d    = grant ? sel_byte : o_tx_data;
        gid_d     = grant ? winner : o_grant_id;
        ready_d   = (state_q == ST_LAUNCH);
        busy_d    = (state_d != ST_IDLE);
        timeout_d = o_timeout | timeout_hit;

        cnt_d = cnt_q;
        if (state_q == ST_LAUNCH) begin
            cnt_d = '0;
        end else if (state_q == ST_WAIT_BUSY) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: self-checking bench for uart_tx_arbiter (N=4, TIMEOUT=64) with a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: the bench plays the transmitter by driving i_tx_next directly.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 64;
    localparam int TW      = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        tx_next;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N       (N),
        .TIMEOUT (TIMEOUT),
        .TW      (TW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .o_req_ack   (ack),
        .o_tx_data   (tx_data),
        .o_tx_ready  (tx_ready),
        .i_tx_next   (tx_next),
        .o_busy      (busy),
        .o_grant_id  (grant_id),
        .o_timeout   (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a transfer is "active" from its grant until the
    // transmitter has gone busy and come back idle, or until the launch has
    // gone unanswered for TIMEOUT cycles. Events are located by cycle age.
    int         m_cyc;
    int         m_grant_cyc;
    int         m_last;
    logic       m_active;
    logic       m_left;
    logic [3:0] e_ack;
    logic       e_ready;
    logic [7:0] e_data;
    logic       e_busy;
    logic       e_timeout;

    always @(posedge clk or posedge rst) begin : model
        logic       act;
        logic       left;
        logic       tmo;
        logic       rdy;
        logic [3:0] ak;
        logic [7:0] dat;
        int         last;
        int         gc;
        int         now;
        int         age;
        int         k;
        if (rst) begin
            m_cyc       <= 0;
            m_grant_cyc <= 0;
            m_last      <= N - 1;
            m_active    <= 1'b0;
            m_left      <= 1'b0;
            e_ack       <= '0;
            e_ready     <= 1'b0;
            e_data      <= '0;
            e_busy      <= 1'b0;
            e_timeout   <= 1'b0;
        end else begin
            now  = m_cyc + 1;
            act  = m_active;
            left = m_left;
            tmo  = e_timeout;
            rdy  = 1'b0;
            ak   = '0;
            dat  = e_data;
            last = m_last;
            gc   = m_grant_cyc;
            if (!act) begin
                if (en && tx_next && (req_valid != 4'h0)) begin
                    for (int d = 1; d <= N; d++) begin
                        k = (m_last + d) % N;
                        if (!act && req_valid[k[1:0]]) begin
                            act  = 1'b1;
                            last = k;
                        end
                    end
                    ak[last[1:0]] = 1'b1;
                    dat  = 8'(req_data >> (8 * last));
                    gc   = now;
                    left = 1'b0;
                end
            end else begin
                age = now - gc;
                if (age == 1) begin
                    rdy = 1'b1;
                end else if (!left) begin
                    if (!tx_next) begin
                        left = 1'b1;
                    end else if (age == TIMEOUT + 1) begin
                        tmo = 1'b1;
                        act = 1'b0;
                    end
                end else if (tx_next) begin
                    act = 1'b0;
                end
            end
            m_cyc       <= now;
            m_grant_cyc <= gc;
            m_last      <= last;
            m_active    <= act;
            m_left      <= left;
            e_ack       <= ak;
            e_ready     <= rdy;
            e_data      <= dat;
            e_busy      <= act;
            e_timeout   <= tmo;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cyc_ack",      32'(ack),      32'(e_ack));
        chk("cyc_tx_ready", 32'(tx_ready), 32'(e_ready));
        chk("cyc_tx_data",  32'(tx_data),  32'(e_data));
        chk("cyc_busy",     32'(busy),     32'(e_busy));
        chk("cyc_grant_id", 32'(grant_id), 32'(m_last));
        chk("cyc_timeout",  32'(timeout),  32'(e_timeout));
    end

    // Waits (bounded) for an ack and compares its index; -1 means none came.
    task automatic wait_ack(input string tag, input int exp_idx);
        int idx;
        idx = -1;
        for (int n = 0; n < 400 && idx < 0; n++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (ack[k]) idx = k;
            end
        end
        chk({tag, "_ack_idx"}, 32'(idx), 32'(exp_idx));
    endtask

    // Called at the ack cycle: checks the launch strobe, then plays a frame of len cycles.
    task automatic run_frame(input string tag, input logic [7:0] exp_data, input int len);
        @(negedge clk);
        chk({tag, "_ready"}, 32'(tx_ready), 32'd1);
        chk({tag, "_data"},  32'(tx_data),  32'(exp_data));
        tx_next = 1'b0;
        repeat (len) @(negedge clk);
        chk({tag, "_busy_mid"}, 32'(busy), 32'd1);
        tx_next = 1'b1;
        @(negedge clk);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic count_acks(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (ack != 4'h0) cnt++;
        end
    endtask

    initial begin : stim
        int n;
        int cnt;
        rst       = 1'b1;
        en        = 1'b0;
        tx_next   = 1'b1;
        req_valid = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant_id", 32'(grant_id), 32'd3);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_tx_data",  32'(tx_data),  32'h00);
        chk("rst_timeout",  32'(timeout),  32'd0);
        chk("rst_ack",      32'(ack),      32'd0);
        rst = 1'b0;
        en  = 1'b1;

        // Round robin with all four holding valid.
        req_data  = 32'h13121110;
        req_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_ack("rr", i % 4);
            if (i == 4) req_valid = 4'h0;
            run_frame("rr", 8'(8'h10 + (i % 4)), 20);
        end

        // Single requester 1, long frame.
        req_data  = 32'h0000A500;
        req_valid = 4'b0010;
        wait_ack("single", 1);
        req_valid = 4'h0;
        run_frame("single", 8'hA5, 160);

        // Transmitter not idle: no grant until i_tx_next rises.
        tx_next   = 1'b0;
        req_data  = 32'h0000005A;
        req_valid = 4'b0001;
        count_acks(30, cnt);
        chk("notidle_no_ack", 32'(cnt), 32'd0);
        tx_next = 1'b1;
        wait_ack("notidle", 0);
        req_valid = 4'h0;
        run_frame("notidle", 8'h5A, 10);

        // Timeout: transmitter never leaves idle.
        req_data  = 32'h33000000;
        req_valid = 4'b1000;
        wait_ack("tmo", 3);
        req_valid = 4'h0;
        @(negedge clk);
        chk("tmo_ready", 32'(tx_ready), 32'd1);
        n = 0;
        while (!timeout && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'(TIMEOUT));
        chk("tmo_busy", 32'(busy), 32'd0);
        req_data  = 32'h00440000;
        req_valid = 4'b0100;
        wait_ack("tmo_next", 2);
        req_valid = 4'h0;
        run_frame("tmo_next", 8'h44, 10);
        chk("tmo_sticky", 32'(timeout), 32'd1);

        // Enable gating.
        en        = 1'b0;
        req_data  = 32'h00220000;
        req_valid = 4'b0100;
        count_acks(100, cnt);
        chk("en_off_no_ack", 32'(cnt), 32'd0);
        en = 1'b1;
        wait_ack("en_on", 2);
        @(negedge clk);
        chk("en_on_ready", 32'(tx_ready), 32'd1);
        tx_next = 1'b0;
        repeat (10) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        chk("en_mid_busy", 32'(busy), 32'd1);
        tx_next = 1'b1;
        count_acks(20, cnt);
        chk("en_drop_no_ack", 32'(cnt), 32'd0);
        chk("en_drop_idle", 32'(busy), 32'd0);
        en = 1'b1;
        wait_ack("en_resume", 2);
        req_valid = 4'h0;
        run_frame("en_resume", 8'h22, 8);

        // Asynchronous reset while the transmitter is mid-frame.
        req_data  = 32'h00007700;
        req_valid = 4'b0010;
        wait_ack("arst", 1);
        req_valid = 4'h0;
        @(negedge clk);
        tx_next = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_ack",      32'(ack),      32'd0);
        chk("arst_ready",    32'(tx_ready), 32'd0);
        chk("arst_tx_data",  32'(tx_data),  32'h00);
        chk("arst_busy",     32'(busy),     32'd0);
        chk("arst_grant_id", 32'(grant_id), 32'd3);
        chk("arst_timeout",  32'(timeout),  32'd0);
        @(negedge clk);
        rst       = 1'b0;
        tx_next   = 1'b1;
        req_data  = 32'hD3C2B1A0;
        req_valid = 4'hF;
        wait_ack("arst_after", 0);
        req_valid = 4'h0;
        run_frame("arst_after", 8'hA0, 6);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
